bc_somador: RTL and testbench

Control block (BC) for the accumulate-and-count operative block. It sequences that datapath through one summation job: clear the accumulator, load the counter, accept one value per handshake while decrementing the counter, and stop when the datapath reports zero. It sits between the job requester (start/abort/done) and the operative block's control inputs (rac, cac, set, dec) and status output (zero).

---
 rtl/bc_somador.sv | 102 ++++++++++
 tb/tb_bc_somador.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_somador.sv
// Control block for the accumulate-and-count datapath: sequences clear/load,
// one accumulate+decrement per accepted value, and completion on counter zero.
module bc_somador #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic in_valid,
    input  logic zero,
    output logic in_ready,
    output logic rac,
    output logic cac,
    output logic set,
    output logic dec,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SETTLE,
        S_TEST,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        in_ready = 1'b0;
        rac      = 1'b0;
        cac      = 1'b0;
        set      = 1'b0;
        dec      = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);

        // abort wins over every pulse, including a pending done
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_INIT;
            end
            S_INIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    rac     = 1'b1;
                    set     = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TEST;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_TEST: begin
                if (abort)     state_d = S_IDLE;
                else if (zero) state_d = S_DONE;
                else           state_d = S_WAIT;
            end
            S_WAIT: begin
                in_ready = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    cac     = 1'b1;
                    dec     = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!abort) done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bc_somador.sv
// Bench for bc_somador: models the operative block (counter, accumulator, value
// bus) and checks job timing derived from the state-sequence rules.
module tb_bc_somador;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, in_valid, zero;
    int unsigned sel;

    logic in_ready1, rac1, cac1, set1, dec1, busy1, done1;
    logic in_ready3, rac3, cac3, set3, dec3, busy3, done3;
    logic o_in_ready, o_rac, o_cac, o_set, o_dec, o_busy, o_done;

    bc_somador #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .start(start & (sel == 0)), .abort(abort & (sel == 0)),
        .in_valid(in_valid & (sel == 0)), .zero(zero),
        .in_ready(in_ready1), .rac(rac1), .cac(cac1), .set(set1),
        .dec(dec1), .busy(busy1), .done(done1)
    );

    bc_somador #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .start(start & (sel == 1)), .abort(abort & (sel == 1)),
        .in_valid(in_valid & (sel == 1)), .zero(zero),
        .in_ready(in_ready3), .rac(rac3), .cac(cac3), .set(set3),
        .dec(dec3), .busy(busy3), .done(done3)
    );

    assign o_in_ready = (sel == 0) ? in_ready1 : in_ready3;
    assign o_rac      = (sel == 0) ? rac1      : rac3;
    assign o_cac      = (sel == 0) ? cac1      : cac3;
    assign o_set      = (sel == 0) ? set1      : set3;
    assign o_dec      = (sel == 0) ? dec1      : dec3;
    assign o_busy     = (sel == 0) ? busy1     : busy3;
    assign o_done     = (sel == 0) ? done1     : done3;

    // Operative block: counter loaded with the job length, zero decoded from it,
    // accumulator fed from a queue of values presented on the value bus.
    int   cnt = 0, acc = 0, vidx = 0, job_len = 0, dec_at_zero = 0;
    int   vals[$];
    logic m_set = 0, m_rac = 0, m_cac = 0, m_dec = 0;

    assign zero = (cnt == 0);

    always @(negedge clk) begin
        m_set = o_set;
        m_rac = o_rac;
        m_cac = o_cac;
        m_dec = o_dec;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (m_rac) acc <= 0;
            if (m_cac) begin
                acc  <= acc + ((vidx < vals.size()) ? vals[vidx] : 0);
                vidx <= vidx + 1;
            end
            if (m_set) begin
                cnt  <= job_len;
                vidx <= 0;
            end else if (m_dec) begin
                if (cnt == 0) dec_at_zero <= dec_at_zero + 1;
                cnt <= cnt - 1;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {o_in_ready, o_rac, o_cac, o_set, o_dec, o_busy, o_done};
    endfunction

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0: start sampled at the end of this cycle.
    task automatic start_job();
        start = 1; abort = 0; in_valid = 0;
        to_sample();
        to_drive();
        start = 0;
    endtask

    task automatic fill_random(input int len);
        vals.delete();
        for (int i = 0; i < len; i++) vals.push_back(int'($urandom_range(1, 255)));
    endtask

    // mode 0: in_valid held high; 1: random in_valid; 2: 10-cycle stall after first transfer
    task automatic run_job(input int len, input int s, input int mode, input int stray_t,
                           input string tag);
        int n_rac = 0, n_set = 0, n_cac = 0;
        int rac_t = -1, set_t = -1, done_t = -1, last_k = -1;
        int pair_bad = 0, busy_bad = 0, gap_bad = 0, stall = 0, hold_bad = 0;
        int exp_sum = 0, exp_done;
        bit fin = 0;
        foreach (vals[i]) exp_sum += vals[i];
        job_len = len;
        start_job();
        for (int t = 1; t <= 400 && !fin; t++) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = !(n_cac == 1 && stall < 10);
            endcase
            start = (t == stray_t);
            to_sample();
            if (o_rac) begin n_rac++; rac_t = t; end
            if (o_set) begin n_set++; set_t = t; end
            if (o_cac) begin
                if (last_k >= 0) begin
                    if (mode == 0 ? (t - last_k) != s + 2 : (t - last_k) < s + 2) gap_bad++;
                end
                n_cac++;
                last_k = t;
                if (!o_dec || !o_in_ready) pair_bad++;
            end else if (o_dec) begin
                pair_bad++;
            end
            if (!o_busy) busy_bad++;
            if (mode == 2 && n_cac == 1 && !in_valid) begin
                if (o_in_ready) stall++;
                else if (stall > 0) hold_bad++;
            end
            if (o_done) begin done_t = t; fin = 1; end
            to_drive();
        end
        start = 0; in_valid = 0;
        exp_done = (mode == 0) ? s + 3 + len * (s + 2) : ((len == 0) ? s + 3 : last_k + s + 2);
        chk({tag, "_done_seen"}, 32'(fin), 1);
        chk({tag, "_rac_count"}, n_rac, 1);
        chk({tag, "_rac_cycle"}, rac_t, 1);
        chk({tag, "_set_count"}, n_set, 1);
        chk({tag, "_set_cycle"}, set_t, 1);
        chk({tag, "_cac_count"}, n_cac, len);
        chk({tag, "_cac_dec_ready_pairing"}, pair_bad, 0);
        chk({tag, "_busy_gaps"}, busy_bad, 0);
        chk({tag, "_transfer_spacing"}, gap_bad, 0);
        chk({tag, "_done_cycle"}, done_t, exp_done);
        chk({tag, "_sum"}, acc, exp_sum);
        chk({tag, "_dec_at_zero"}, dec_at_zero, 0);
        if (mode == 2) begin
            chk({tag, "_stall_cycles"}, stall, 10);
            chk({tag, "_stall_hold"}, hold_bad, 0);
        end
        to_sample();
        chk({tag, "_busy_after_done"}, 32'(o_busy), 0);
        chk({tag, "_done_width"}, 32'(o_done), 0);
        to_drive();
    endtask

    initial begin
        int waited;
        sel = 0; start = 0; abort = 0; in_valid = 0;
        rst = 1;
        #2 rst = 0;
        #1 chk("reset_outputs_async", 32'(outs()), 0);
        to_drive();
        to_drive();
        rst = 1;
        to_sample();
        chk("idle_after_reset", 32'(outs()), 0);
        to_drive();

        // Normal job, values 5,7,9
        vals = '{5, 7, 9};
        run_job(3, 1, 0, 0, "normal");
        chk("normal_sum_21", acc, 21);

        // Zero-length job
        vals.delete();
        run_job(0, 1, 0, 0, "zero_len");

        // Backpressure
        vals = '{11, 22, 33};
        run_job(3, 1, 2, 0, "backpressure");

        // start with abort in IDLE stays idle
        start = 1; abort = 1;
        to_sample();
        to_drive();
        start = 0; abort = 0;
        to_sample();
        chk("idle_start_abort", 32'(o_busy), 0);
        to_drive();

        // Abort in WAIT with in_valid high
        vals = '{1, 2, 3};
        job_len = 3;
        start_job();
        waited = 0;
        to_sample();
        while (!o_in_ready && waited < 20) begin
            to_drive();
            to_sample();
            waited++;
        end
        chk("abort_reached_wait", 32'(o_in_ready), 1);
        to_drive();
        in_valid = 1; abort = 1;
        to_sample();
        chk("abort_no_cac", 32'(o_cac), 0);
        chk("abort_no_dec", 32'(o_dec), 0);
        chk("abort_no_done", 32'(o_done), 0);
        to_drive();
        in_valid = 0; abort = 0;
        to_sample();
        chk("abort_busy_drop", 32'(o_busy), 0);
        chk("abort_acc_kept", acc, 0);
        to_drive();
        vals = '{4, 6, 8};
        run_job(3, 1, 0, 0, "after_abort");

        // Abort in DONE suppresses done
        vals.delete();
        job_len = 0;
        start_job();
        for (int t = 1; t <= 3; t++) begin
            to_sample();
            to_drive();
        end
        abort = 1;
        to_sample();
        chk("abort_in_done_busy", 32'(o_busy), 1);
        chk("abort_in_done_no_done", 32'(o_done), 0);
        to_drive();
        abort = 0;
        to_sample();
        chk("abort_in_done_idle", 32'(o_busy), 0);
        to_drive();

        // Async reset during SETTLE
        vals = '{9, 9, 9};
        job_len = 3;
        start_job();
        to_sample();
        to_drive();
        to_sample();
        chk("pre_reset_busy", 32'(o_busy), 1);
        #2 rst = 0;
        #1 chk("reset_mid_job_outputs", 32'(outs()), 0);
        to_drive();
        to_drive();
        rst = 1;
        in_valid = 1;
        waited = 0;
        for (int t = 0; t < 4; t++) begin
            to_sample();
            if (outs() != '0) waited++;
            to_drive();
        end
        in_valid = 0;
        chk("post_reset_quiet", waited, 0);

        // SETTLE_CYCLES=3 with a stray start in the first WAIT cycle
        sel = 1;
        vals = '{3, 5, 7};
        run_job(3, 3, 0, 6, "settle3_stray_start");

        // Randomized jobs on both instances
        for (int j = 0; j < 8; j++) begin
            int len;
            sel = j % 2;
            len = int'($urandom_range(0, 4));
            fill_random(len);
            run_job(len, (sel == 0) ? 1 : 3, 1, 0, $sformatf("rand%0d", j));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
